i2c_poll_sampler: RTL and testbench

Periodic poll controller and sample conditioner that sits directly between the I2C sensor wrapper and the VGA drawing logic. It raises the I2C master's enable at a fixed interval, tracks the master's busy handshake, captures each completed 16-bit read, optionally block-averages captures, and presents one registered sample with a one-cycle valid strobe. A watchdog aborts transactions that never complete and counts them.

---
 rtl/i2c_poll_sampler.sv | 183 ++++++++++++++++++
 tb/tb_i2c_poll_sampler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_poll_sampler.sv
// Periodic I2C poll controller and sample conditioner with a transaction watchdog.
// Define I2C_SAMPLE_AVG_EN to block-average 2^AVG_LOG2 captures per output sample.
module i2c_poll_sampler #(
  parameter int POLL_PERIOD    = 500000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int AVG_LOG2       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        i2c_busy,
  input  logic [15:0] i2c_data,
  output logic        i2c_enable,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic [7:0]  error_count
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PERIOD_LOAD  = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT_DONE,
    S_CAPTURE,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          enable_q, enable_d;
  logic [15:0]   data_q, data_d;
  logic [15:0]   sample_q, sample_d;
  logic          valid_q, valid_d;
  logic [7:0]    err_q, err_d;

  logic          abort;
  logic          cap_valid;
  logic [15:0]   cap_value;

  assign abort = ((state_q == S_REQUEST) || (state_q == S_WAIT_DONE)) &&
                 (timeout_q == TIMEOUT_LAST);

`ifdef I2C_SAMPLE_AVG_EN
  localparam int AW = 16 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc_q, acc_d, acc_sum;
  logic [CW-1:0] cnt_q, cnt_d;

  // Partial sums are discarded on a watchdog abort or while parked with run low.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    cap_valid = 1'b0;
    acc_sum   = acc_q + AW'(data_q);
    cap_value = 16'(acc_sum >> AVG_LOG2);
    if (abort || ((state_q == S_IDLE) && !run)) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == S_CAPTURE) begin
      if (cnt_q == CNT_LAST) begin
        cap_valid = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign cap_valid = 1'b1;
  assign cap_value = data_q;
`endif

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    timeout_d = timeout_q;
    data_d    = data_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    err_d     = err_q;

    if ((state_q != S_IDLE) && (period_q != '0)) begin
      period_d = period_q - 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d   = S_REQUEST;
          period_d  = PERIOD_LOAD;
          timeout_d = '0;
        end
      end
      S_REQUEST, S_WAIT_DONE: begin
        if (abort) begin
          state_d = S_HOLD;
          if (err_q != 8'hFF) begin
            err_d = err_q + 1'b1;
          end
        end else begin
          timeout_d = timeout_q + 1'b1;
          if ((state_q == S_REQUEST) && i2c_busy) begin
            state_d = S_WAIT_DONE;
          end else if ((state_q == S_WAIT_DONE) && !i2c_busy) begin
            state_d = S_CAPTURE;
            data_d  = i2c_data;
          end
        end
      end
      S_CAPTURE: begin
        state_d = S_HOLD;
        if (cap_valid) begin
          sample_d = cap_value;
          valid_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (period_q == '0) begin
          if (run) begin
            state_d   = S_REQUEST;
            period_d  = PERIOD_LOAD;
            timeout_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Enable is a registered copy of "in REQUEST", so an abort drops it on the same edge.
    enable_d = (state_d == S_REQUEST);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      period_q  <= '0;
      timeout_q <= '0;
      enable_q  <= 1'b0;
      data_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
      enable_q  <= enable_d;
      data_q    <= data_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign i2c_enable   = enable_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign error_count  = err_q;

endmodule

// File: tb/tb_i2c_poll_sampler.sv
// Scoreboard bench for i2c_poll_sampler: a behavioural I2C master model pushes expected
// samples when each read completes; a negedge monitor pops them when the DUT strobes.
module tb_i2c_poll_sampler;

  localparam int POLL     = 64;
  localparam int TMO      = 32;
  localparam int AVG_LOG2 = 2;
  localparam int AVG_N    = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        reset, run, i2c_busy, never_busy;
  logic [15:0] resp_data, sample;
  logic        i2c_enable, sample_valid;
  logic [7:0]  error_count;

  logic        run2, busy2, en2, valid2;
  logic [15:0] data2 = 16'h5A5A;
  logic [15:0] sample2;
  logic [7:0]  err2;

  int          n_vec = 0;
  int          n_err = 0;
  int          n;
  logic [15:0] sb_q[$];
  logic [15:0] vals[4] = '{16'd100, 16'd101, 16'd102, 16'd104};

  always #5 clk = ~clk;

  i2c_poll_sampler #(.POLL_PERIOD(POLL), .TIMEOUT_CYCLES(TMO), .AVG_LOG2(AVG_LOG2)) u_dut (
    .clk(clk), .reset(reset), .run(run), .i2c_busy(i2c_busy), .i2c_data(resp_data),
    .i2c_enable(i2c_enable), .sample(sample), .sample_valid(sample_valid),
    .error_count(error_count)
  );

  i2c_poll_sampler #(.POLL_PERIOD(POLL), .TIMEOUT_CYCLES(128), .AVG_LOG2(AVG_LOG2)) u_long (
    .clk(clk), .reset(reset), .run(run2), .i2c_busy(busy2), .i2c_data(data2),
    .i2c_enable(en2), .sample(sample2), .sample_valid(valid2), .error_count(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Counts negedges until the selected signal equals lvl; n = -1 if the budget expires.
  task automatic wait_sig(input int which, input logic lvl, input int max, output int cnt);
    logic v;
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      case (which)
        0:       v = i2c_enable;
        1:       v = sample_valid;
        2:       v = i2c_busy;
        default: v = en2;
      endcase
      if (v === lvl) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Master model: busy rises 2 cycles after enable is seen, stays high busy_len cycles.
  int          en_seen, hold;
  logic [19:0] m_acc;
  int          m_n;
  always @(posedge clk) begin
    if (reset) begin
      i2c_busy <= 1'b0;
      en_seen  <= 0;
      hold     <= 0;
      m_acc    <= '0;
      m_n      <= 0;
    end else begin
      if (i2c_busy) begin
        hold <= hold - 1;
        if (hold == 1) begin
          i2c_busy <= 1'b0;
`ifdef I2C_SAMPLE_AVG_EN
          if (m_n == AVG_N - 1) begin
            sb_q.push_back(16'((m_acc + 20'(resp_data)) >> AVG_LOG2));
            m_acc <= '0;
            m_n   <= 0;
          end else begin
            m_acc <= m_acc + 20'(resp_data);
            m_n   <= m_n + 1;
          end
`else
          sb_q.push_back(resp_data);
`endif
        end
      end else if (i2c_enable) begin
        if (en_seen == 1 && !never_busy) begin
          i2c_busy <= 1'b1;
          hold     <= 10;
          en_seen  <= 0;
        end else begin
          en_seen <= en_seen + 1;
        end
      end else begin
        if (en_seen != 0) begin
          m_acc <= '0;
          m_n   <= 0;
        end
        en_seen <= 0;
      end
      if (!run && !i2c_busy) begin
        m_acc <= '0;
        m_n   <= 0;
      end
    end
  end

  int seen2, hold2;
  always @(posedge clk) begin
    if (reset) begin
      busy2 <= 1'b0;
      seen2 <= 0;
      hold2 <= 0;
    end else if (busy2) begin
      hold2 <= hold2 - 1;
      if (hold2 == 1) busy2 <= 1'b0;
    end else if (en2) begin
      if (seen2 == 1) begin
        busy2 <= 1'b1;
        hold2 <= 80;
        seen2 <= 0;
      end else begin
        seen2 <= seen2 + 1;
      end
    end else begin
      seen2 <= 0;
    end
  end

  logic prev_valid;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (sample_valid) begin
        check("valid_1cyc", 32'(prev_valid), 0);
        check("sb_pending", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) check("sample", sample, sb_q.pop_front());
      end
      prev_valid <= sample_valid;
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; run2 = 1'b0; never_busy = 1'b0; resp_data = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_enable", i2c_enable, 0);
    check("rst_sample", sample, 16'h0000);
    check("rst_valid",  sample_valid, 0);
    check("rst_errors", error_count, 0);
    check("rst_en_long", en2, 0);
    reset = 1'b0;
    run   = 1'b1;

    wait_sig(0, 1'b1, 10, n);
    check("first_en", n, 1);
`ifndef I2C_SAMPLE_AVG_EN
    wait_sig(0, 1'b0, 20, n);
    check("en_high_cycles", n, 3);
    wait_sig(2, 1'b0, 30, n);
    check("busy_len", n, 9);
    wait_sig(1, 1'b1, 10, n);
    check("valid_latency", n, 2);
    check("sample_1234", sample, 16'h1234);
    wait_sig(0, 1'b1, 100, n);
    check("poll_period", n + 14, POLL);
`else
    for (int k = 0; k < AVG_N; k++) begin
      if (k != 0) wait_sig(0, 1'b1, 100, n);
      resp_data = vals[k];
      wait_sig(0, 1'b0, 20, n);
    end
    wait_sig(1, 1'b1, 30, n);
    check("avg_strobe_lat", n, 11);
    check("avg_sample", sample, 16'd101);
    wait_sig(0, 1'b1, 100, n);
`endif

    // Master never answers: watchdog aborts, counts, and the poll grid is kept.
    never_busy = 1'b1;
    wait_sig(0, 1'b0, 60, n);
    check("timeout_en_width", n, TMO);
    check("timeout_errors", error_count, 1);
    wait_sig(0, 1'b1, 100, n);
    check("timeout_next_req", n, POLL - TMO);
    for (int i = 0; i < 299; i++) begin
      wait_sig(0, 1'b0, 60, n);
      wait_sig(0, 1'b1, 60, n);
    end
    check("errors_saturate", error_count, 8'd255);

    // run dropped during WAIT_DONE: the read still completes, then polling stops.
    never_busy = 1'b0;
    resp_data  = 16'hBEEF;
    wait_sig(0, 1'b0, 20, n);
    check("stop_en_high", n, 3);
    run = 1'b0;
`ifndef I2C_SAMPLE_AVG_EN
    wait_sig(1, 1'b1, 30, n);
    check("stop_valid_lat", n, 11);
    check("stop_sample", sample, 16'hBEEF);
`endif
    wait_sig(0, 1'b1, 200, n);
    check("stop_no_enable", n, -1);
    check("stop_errors", error_count, 8'd255);

    // Reset in the middle of WAIT_DONE.
    run = 1'b1;
    wait_sig(0, 1'b1, 10, n);
    wait_sig(0, 1'b0, 20, n);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_enable", i2c_enable, 0);
    check("mid_rst_sample", sample, 16'h0000);
    check("mid_rst_valid",  sample_valid, 0);
    check("mid_rst_errors", error_count, 0);
    reset = 1'b0;
    wait_sig(0, 1'b1, 10, n);
    check("rst_release_en", n, 1);

    // Transaction longer than the poll period: HOLD lasts one cycle.
    run2 = 1'b1;
    wait_sig(3, 1'b1, 10, n);
    check("long_first_en", n, 1);
    wait_sig(3, 1'b0, 20, n);
    check("long_en_high", n, 3);
    wait_sig(3, 1'b1, 200, n);
    check("long_rerequest", n, 82);
`ifndef I2C_SAMPLE_AVG_EN
    check("long_sample", sample2, 16'h5A5A);
`endif
    run2 = 1'b0;

    run = 1'b0;
    repeat (200) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
